// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared FSM state type and default parameters for the serial transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CLKS_PER_BIT_DEF = 4;
    localparam int DATA_W_DEF       = 8;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: counts enabled cycles within one serial bit and pulses bit_done
// on the last cycle of each bit. Cleared when a new frame is accepted.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic bit_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // bit_done is combinational so the FSM moves on the same edge the counter wraps
    assign bit_done = run && (cnt == LAST);

    // Bit-cycle counter: wraps from CLKS_PER_BIT-1 to 0, frozen when not running
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: start/data/stop serial transmitter, LSB first, txd idles high.
// One payload in flight at a time; en low freezes all state.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              txd,
    output logic              busy
);

    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic              accept;
    logic              bit_done;

    // ready is forced low during reset even though state already reads IDLE
    assign ready  = (state == IDLE) && en && !reset;
    assign accept = valid && ready;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (en && (state != IDLE)),
        .clr      (accept),
        .bit_done (bit_done)
    );

    // Frame sequencer: txd, busy, shift register and bit index are all registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
            shreg <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= data_in;
                        txd   <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        txd   <= shreg[0];
                        shreg <= shreg >> 1;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (idx == IDX_LAST) begin
                            txd   <= 1'b1;
                            idx   <= '0;
                            state <= STOP;
                        end else begin
                            txd   <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (legal range 2..255).
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning payload bits per frame.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port en  input  1  global enable; when low, the block SHALL freeze.
REQ-006 The module SHALL have port data_in  input  DATA_W  parallel payload, sampled on acceptance.
REQ-007 The module SHALL have port valid  input  1  the producer offers data_in.
REQ-008 The module SHALL have port ready  output  1  the block can accept a payload this cycle.
REQ-009 The module SHALL have port txd  output  1  serial line; it SHALL idle high.
REQ-010 The module SHALL have port busy  output  1  high while a frame is in flight.

Function
REQ-011 The state machine SHALL have states IDLE, START, DATA and STOP.
REQ-012 ready SHALL equal (state==IDLE) && en, combinationally.
REQ-013 A payload SHALL be accepted on a rising edge where valid && ready; data_in SHALL be latched into a shift register and the state SHALL move to START.
REQ-014 txd SHALL be registered: it SHALL be low (start bit) from the cycle after acceptance.
REQ-015 Each of START, DATA bit 0..DATA_W-1 and STOP SHALL hold txd for exactly CLKS_PER_BIT enabled cycles.
REQ-016 Data bits SHALL be sent LSB first; the stop bit SHALL be high.
REQ-017 A frame SHALL occupy (DATA_W+2)*CLKS_PER_BIT enabled cycles.
REQ-018 After STOP the state SHALL return to IDLE, giving at least one IDLE cycle between frames.
REQ-019 busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-020 When en is low, the bit counter, bit index, shift register, state and txd SHALL hold their values, and no acceptance SHALL occur.
REQ-021 If valid is high but ready is low, data_in SHALL be ignored; the block SHALL never queue a second payload.
REQ-022 The bit-cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap from CLKS_PER_BIT-1 to 0.
REQ-023 The bit index SHALL be $clog2(DATA_W) bits wide and SHALL advance on counter wrap only.

Reset
REQ-024 While reset is high, regardless of clk, the outputs SHALL be: state=IDLE, txd=1, busy=0, counter=0, index=0, shift register=0.
REQ-025 ready SHALL be 0 while reset is high.
REQ-026 A reset asserted mid-frame SHALL abort the frame immediately, with txd high.
REQ-027 After reset is released, the block SHALL accept a new payload on the first enabled edge with valid high.

Structure
REQ-028 Package serial_tx_pkg SHALL hold the state enum (2 bits) and the default constants CLKS_PER_BIT_DEF=4 and DATA_W_DEF=8.
REQ-029 One sub-module, bit_timer, SHALL generate a one-cycle bit_done pulse every CLKS_PER_BIT enabled cycles; it SHALL be cleared on frame start.

Verification
REQ-030 Scenario "reset then idle": reset high 10 ns, then low; en=1, valid=0 -> txd=1, busy=0, ready=1 throughout.
REQ-031 Scenario "single frame": data_in=8'hA5, valid pulsed one cycle -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high 40 cycles; then ready=1.
REQ-032 Scenario "back-to-back": valid held high with 8'h3C then 8'hC3 -> two frames separated by exactly 1 idle cycle; the second payload is captured only when ready=1.
REQ-033 Scenario "enable stall": en low for 7 cycles during DATA bit 3 of 8'hA5 -> txd holds its bit value; the frame completes in 40+7 cycles with unchanged bit order.
REQ-034 Scenario "reset mid-frame": reset pulsed 5 ns during DATA bit 2 -> txd=1 asynchronously, busy=0; the next frame with 8'hFF is sent correctly.
REQ-035 Scenario "ignored valid": while busy, data_in=8'h00 with valid=1 -> the current frame is unaffected and 8'h00 is accepted only after return to IDLE.
